reset_sequencer: RTL and testbench

//  Consumes the synchronized board reset and PLL lock, then releases domain resets in order: SDRAM controller

---
 rtl/reset_sequencer_pkg.sv | 18 +
 rtl/reset_sequencer_lock_filter.sv | 19 +
 rtl/reset_sequencer.sv | 148 ++++++++++++++
 tb/tb_reset_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state encoding and counter sizing shared by the reset sequencer
package reset_sequencer_pkg;
  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STRETCH    = 3'd1,
    SDRAM_INIT = 3'd2,
    SYS_REL    = 3'd3,
    RUN        = 3'd4,
    SOFT_RST   = 3'd5,
    FAULT      = 3'd6
  } seq_state_e;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// lock_filter: qualifies pllLocked once it has been high for LOCK_FILTER consecutive cycles
module lock_filter #(
  parameter int LOCK_FILTER = 4
) (
  input  logic clk,
  input  logic rstIn,
  input  logic pllLocked,
  output logic lockOk
);
  localparam int LW = $clog2(LOCK_FILTER + 1);
  localparam logic [LW-1:0] LIM = LW'(LOCK_FILTER - 1);
  logic [LW-1:0] cnt_q, cnt_d;
  // the current high sample counts toward the run, so lockOk fires on the LOCK_FILTER-th high cycle
  assign lockOk = pllLocked && cnt_q >= LIM;
  always_comb cnt_d = !pllLocked ? '0 : (cnt_q >= LIM ? cnt_q : cnt_q + LW'(1));
  always_ff @(posedge clk)
    if (rstIn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases SDRAM, fabric and CPU resets in order after PLL lock, with soft reset and init retry
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int LOCK_FILTER    = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int INIT_TIMEOUT   = 1000000,
  parameter int CPU_DELAY      = 8,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rstIn,
  input  logic       pllLocked,
  input  logic       sdramInitDone,
  input  logic       extResetReq,
  output logic       sdramRstOut,
  output logic       sysRstOut,
  output logic       cpuRstOut,
  output logic       ready,
  output logic       fault,
  output logic [2:0] seqState
);
  localparam int CW = cnt_width(INIT_TIMEOUT, STRETCH_CYCLES, CPU_DELAY);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(INIT_TIMEOUT - 1);
  localparam logic [CW-1:0] CPU_LAST     = CW'(CPU_DELAY - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);
  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic sdram_rst_q, sdram_rst_d, sys_rst_q, sys_rst_d, cpu_rst_q, cpu_rst_d;
  logic ready_q, ready_d, fault_q, fault_d;
  logic lock_ok;
  lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock_filter (
    .clk      (clk),
    .rstIn    (rstIn),
    .pllLocked(pllLocked),
    .lockOk   (lock_ok)
  );
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    sdram_rst_d = sdram_rst_q;
    sys_rst_d   = sys_rst_q;
    cpu_rst_d   = cpu_rst_q;
    ready_d     = ready_q;
    fault_d     = fault_q;
    if (state_q != WAIT_LOCK && !pllLocked) begin
      state_d     = WAIT_LOCK;
      cnt_d       = '0;
      retry_d     = '0;
      sdram_rst_d = 1'b1;
      sys_rst_d   = 1'b1;
      cpu_rst_d   = 1'b1;
      ready_d     = 1'b0;
      fault_d     = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          sdram_rst_d = 1'b1;
          sys_rst_d   = 1'b1;
          cpu_rst_d   = 1'b1;
          ready_d     = 1'b0;
          fault_d     = 1'b0;
          cnt_d       = '0;
          state_d     = lock_ok ? STRETCH : WAIT_LOCK;
        end
        STRETCH: begin
          cnt_d       = cnt_q >= STRETCH_LAST ? '0 : cnt_q + CW'(1);
          sdram_rst_d = cnt_q < STRETCH_LAST;
          state_d     = cnt_q >= STRETCH_LAST ? SDRAM_INIT : STRETCH;
        end
        SDRAM_INIT: begin
          if (sdramInitDone) begin
            sys_rst_d = 1'b0;
            cnt_d     = '0;
            state_d   = SYS_REL;
          end else if (cnt_q >= TIMEOUT_LAST) begin
            retry_d     = retry_q + RW'(1);
            sdram_rst_d = 1'b1;
            cnt_d       = '0;
            fault_d     = retry_d >= RETRY_MAX;
            state_d     = retry_d >= RETRY_MAX ? FAULT : STRETCH;
          end else cnt_d = cnt_q + CW'(1);
        end
        SYS_REL: begin
          cnt_d     = cnt_q >= CPU_LAST ? '0 : cnt_q + CW'(1);
          cpu_rst_d = cnt_q < CPU_LAST;
          ready_d   = cnt_q >= CPU_LAST;
          state_d   = cnt_q >= CPU_LAST ? RUN : SYS_REL;
        end
        RUN: begin
          cnt_d     = '0;
          cpu_rst_d = extResetReq;
          ready_d   = !extResetReq;
          state_d   = extResetReq ? SOFT_RST : RUN;
        end
        SOFT_RST: begin
          // a held request keeps restarting the stretch so the CPU stays in reset
          if (extResetReq) cnt_d = '0;
          else if (cnt_q >= STRETCH_LAST) begin
            cnt_d     = '0;
            cpu_rst_d = 1'b0;
            ready_d   = 1'b1;
            state_d   = RUN;
          end else cnt_d = cnt_q + CW'(1);
        end
        FAULT: begin
          sdram_rst_d = 1'b1;
          sys_rst_d   = 1'b1;
          cpu_rst_d   = 1'b1;
          ready_d     = 1'b0;
          fault_d     = 1'b1;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rstIn) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      retry_q     <= '0;
      sdram_rst_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      cpu_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sdram_rst_q <= sdram_rst_d;
      sys_rst_q   <= sys_rst_d;
      cpu_rst_q   <= cpu_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end
  assign sdramRstOut = sdram_rst_q;
  assign sysRstOut   = sys_rst_q;
  assign cpuRstOut   = cpu_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign seqState    = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scenario tasks push expected outputs to a scoreboard and compare after each clock edge
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic rstIn = 1'b1, pllLocked = 1'b0, sdramInitDone = 1'b0, extResetReq = 1'b0;
  logic sdramRstOut, sysRstOut, cpuRstOut, ready, fault;
  logic [2:0] seqState;
  logic [7:0] obs;
  logic [2:0] st;
  int vectors = 0, miscompares = 0;
  typedef struct {
    string      tag;
    int         cyc;
    logic [7:0] v;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  localparam logic [7:0] RSTV = 8'b11100_000;
  reset_sequencer #(
    .LOCK_FILTER(4), .STRETCH_CYCLES(4), .INIT_TIMEOUT(20), .CPU_DELAY(2), .MAX_RETRIES(2)
  ) dut (
    .clk          (clk),
    .rstIn        (rstIn),
    .pllLocked    (pllLocked),
    .sdramInitDone(sdramInitDone),
    .extResetReq  (extResetReq),
    .sdramRstOut  (sdramRstOut),
    .sysRstOut    (sysRstOut),
    .cpuRstOut    (cpuRstOut),
    .ready        (ready),
    .fault        (fault),
    .seqState     (seqState)
  );
  always #5 clk = ~clk;
  assign obs = {sdramRstOut, sysRstOut, cpuRstOut, ready, fault, seqState};
  // release order must hold on every cycle
  always @(negedge clk) begin
    vectors++;
    if ((cpuRstOut === 1'b0 && sysRstOut !== 1'b0) || (sysRstOut === 1'b0 && sdramRstOut !== 1'b0)) begin
      miscompares++;
      $display("FAIL order: sdram=%b sys=%b cpu=%b, required no later domain released before an earlier one",
               sdramRstOut, sysRstOut, cpuRstOut);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic logic [7:0] ev(input logic s, y, c, r, f, input logic [2:0] s3);
    return {s, y, c, r, f, s3};
  endfunction
  function automatic void push(input string tag, input int cyc, input logic [7:0] v);
    exp_t x;
    x.tag = tag;
    x.cyc = cyc;
    x.v   = v;
    exp_q.push_back(x);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    sdramInitDone = 1'b0;
    rstIn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pllLocked = k[0];
      extResetReq = (k == 2);
      push("reset", k, RSTV);
      tick;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.v) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %b expected %b", e.tag, e.cyc, obs, e.v);
      end
    end
    extResetReq = 1'b0;
  endtask
  task automatic test_nominal;
    rstIn = 1'b1; pllLocked = 1'b1; extResetReq = 1'b0; sdramInitDone = 1'b0;
    tick;
    rstIn = 1'b0;
    for (int k = 0; k < 22; k++) begin
      sdramInitDone = (k == 17);
      st = k < 3 ? 3'd0 : k < 7 ? 3'd1 : k < 17 ? 3'd2 : k < 19 ? 3'd3 : 3'd4;
      push("nominal", k, ev(k < 7, k < 17, k < 19, k >= 19, 1'b0, st));
      tick;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.v) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %b expected %b", e.tag, e.cyc, obs, e.v);
      end
    end
  endtask
  task automatic test_soft_reset;
    for (int k = 0; k < 14; k++) begin
      extResetReq = k < 6 ? (k == 0) : (k >= 6 && k < 9);
      if (k < 6) push("soft_pulse", k, k < 4 ? ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5) : ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4));
      else push("soft_level", k - 6, k < 12 ? ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5) : ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4));
      tick;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.v) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %b expected %b", e.tag, e.cyc, obs, e.v);
      end
    end
    extResetReq = 1'b0;
  endtask
  task automatic test_lock_loss;
    sdramInitDone = 1'b0;
    for (int k = 0; k < 13; k++) begin
      pllLocked = !(k < 2 || k == 12);
      if (k < 2 || k == 12) push(k < 2 ? "lock_loss_run" : "lock_loss_init", k, RSTV);
      else begin
        st = k - 2 < 3 ? 3'd0 : k - 2 < 7 ? 3'd1 : 3'd2;
        push("relock", k - 2, ev(k - 2 < 7, 1'b1, 1'b1, 1'b0, 1'b0, st));
      end
      tick;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.v) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %b expected %b", e.tag, e.cyc, obs, e.v);
      end
    end
  endtask
  task automatic test_lock_glitch;
    rstIn = 1'b1; sdramInitDone = 1'b0;
    tick;
    rstIn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      pllLocked = (k != 3);
      st = k < 7 ? 3'd0 : k < 11 ? 3'd1 : 3'd2;
      push("lock_glitch", k, ev(k < 11, 1'b1, 1'b1, 1'b0, 1'b0, st));
      tick;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.v) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %b expected %b", e.tag, e.cyc, obs, e.v);
      end
    end
  endtask
  task automatic test_timeout;
    rstIn = 1'b1; pllLocked = 1'b1; sdramInitDone = 1'b0; extResetReq = 1'b0;
    tick;
    rstIn = 1'b0;
    for (int k = 0; k < 57; k++) begin
      extResetReq = (k == 55);
      rstIn = (k == 56);
      st = k < 3 ? 3'd0 : k < 7 ? 3'd1 : k < 27 ? 3'd2 : k < 31 ? 3'd1 : k < 51 ? 3'd2 : 3'd6;
      if (k == 56) push("fault_clear", k, RSTV);
      else push("timeout", k, ev(!((k >= 7 && k < 27) || (k >= 31 && k < 51)), 1'b1, 1'b1, 1'b0, k >= 51, st));
      tick;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.v) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %b expected %b", e.tag, e.cyc, obs, e.v);
      end
    end
    extResetReq = 1'b0;
  endtask
  task automatic test_rst_mid_soft;
    test_nominal;
    for (int k = 0; k < 3; k++) begin
      extResetReq = (k == 0);
      rstIn = (k == 2);
      push("rst_mid_soft", k, k < 2 ? ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5) : RSTV);
      tick;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.v) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %b expected %b", e.tag, e.cyc, obs, e.v);
      end
    end
  endtask
  task automatic test_simultaneous;
    test_nominal;
    for (int k = 0; k < 2; k++) begin
      rstIn = (k == 0);
      extResetReq = (k == 0);
      pllLocked = 1'b0;
      push("simultaneous", k, RSTV);
      tick;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e.v) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %b expected %b", e.tag, e.cyc, obs, e.v);
      end
    end
  endtask
  initial begin
    test_reset;
    test_nominal;
    test_soft_reset;
    test_lock_loss;
    test_lock_glitch;
    test_timeout;
    test_rst_mid_soft;
    test_simultaneous;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
